// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT FSM with stall, branch and jalr redirects.
// Defining PC_SEQUENCER_TRAP_EN adds trap entry (trap_req/trap_vector), mret and the epc register.
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter int              IMM_SHIFT    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_imm,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            halt,
    input  logic            resume,
`ifdef PC_SEQUENCER_TRAP_EN
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret,
    output logic [XLEN-1:0] epc,
`endif
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] seq_pc,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    state_e          cur;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] next_pc;

    assign state  = cur;
    assign seq_pc = pc + INC_V;
    // Two's-complement add makes the offset sign-correct; bits shifted past XLEN are dropped.
    assign br_off = branch_imm << IMM_SHIFT;

    always_comb begin
        next_pc = seq_pc;
`ifdef PC_SEQUENCER_TRAP_EN
        if (mret)
            next_pc = epc;
        else
`endif
        if (jalr_valid)
            next_pc = {jalr_target[XLEN-1:1], 1'b0};
        else if (branch_taken)
            next_pc = pc + br_off;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            cur      <= BOOT;
            pc_valid <= 1'b0;
`ifdef PC_SEQUENCER_TRAP_EN
            epc      <= '0;
`endif
        end else begin
`ifdef PC_SEQUENCER_TRAP_EN
            // A trap outranks every RUN/HALT condition, including stall and halt.
            if (trap_req && cur != BOOT) begin
                pc       <= trap_vector;
                epc      <= pc;
                cur      <= RUN;
                pc_valid <= 1'b1;
            end else
`endif
            case (cur)
                BOOT: begin
                    cur      <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (halt) begin
                        cur      <= HALT;
                        pc_valid <= 1'b0;
                    end else if (!stall) begin
                        pc <= next_pc;
                    end
                end
                HALT: begin
                    if (resume && !halt) begin
                        cur      <= RUN;
                        pc_valid <= 1'b1;
                    end
                end
                default: begin
                    cur      <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
